ddr4_cmd_decoder: RTL and testbench

// - Pin-level DDR4 command decoder inside the DIMM model. Samples the CA bus (cs_n, act_n,
//   adr, ba, bg, cke, par, reset_n) each clock and emits one-cycle command strobes
//   (ACT, RD, WR, PR, REF, ...) plus latched bank/row/col to the downstream timing wrapper.
// - Tracks CKE power state (power-down, self-refresh) and checks CA parity. Commands with a

---
 rtl/ddr4_pkg.sv | 40 ++++
 rtl/ddr4_ca_parity.sv | 40 ++++
 rtl/ddr4_cmd_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_ddr4_cmd_decoder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_pkg.sv
// Shared DDR4 decoder types: power states, {RAS_n,CAS_n,WE_n} opcodes and the
// registered strobe bundle.
package ddr4_pkg;

  typedef enum logic [1:0] {PWRUP, ACTIVE, PDN, SREF} pstate_t;

  localparam logic [2:0] OP_MRS = 3'b000;
  localparam logic [2:0] OP_REF = 3'b001;
  localparam logic [2:0] OP_PRE = 3'b010;
  localparam logic [2:0] OP_RFU = 3'b011;
  localparam logic [2:0] OP_WR  = 3'b100;
  localparam logic [2:0] OP_RD  = 3'b101;
  localparam logic [2:0] OP_ZQC = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  localparam int A10 = 10;

  localparam logic [7:0] ERR_MAX = 8'hFF;

  typedef struct packed {
    logic act;
    logic pr;
    logic pra;
    logic rd;
    logic rda;
    logic wr;
    logic wra;
    logic refr;
    logic mrw;
    logic cfg;
    logic srf;
    logic pd;
    logic pdx;
    logic ckeh;
    logic ckel;
    logic ill;
    logic perr;
  } strobes_t;

endpackage

// File: rtl/ddr4_ca_parity.sv
// Even CA parity check over the sampled pins plus a saturating error counter.
module ddr4_ca_parity
  import ddr4_pkg::*;
#(
  parameter int ADRW      = 17,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            chk_en,
  input  logic            act_n,
  input  logic [ADRW-1:0] adr,
  input  logic [1:0]      bg,
  input  logic [1:0]      ba,
  input  logic            par,
  output logic            mismatch,
  output logic [7:0]      err_cnt
);

  logic [7:0] err_cnt_q, err_cnt_d;

  assign mismatch = PARITY_EN && chk_en && (^{act_n, adr, bg, ba, par});
  assign err_cnt  = err_cnt_q;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (mismatch && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: rtl/ddr4_cmd_decoder.sv
// DDR4 CA-bus command decoder: samples the pins each edge, emits one-cycle command and
// power strobes, and tracks the CKE power state (PWRUP/ACTIVE/PDN/SREF).
module ddr4_cmd_decoder
  import ddr4_pkg::*;
#(
  parameter int ADRW      = 17,
  parameter int COLW      = 10,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reset_n,
  input  logic            cke,
  input  logic            cs_n,
  input  logic            act_n,
  input  logic [ADRW-1:0] adr,
  input  logic [1:0]      ba,
  input  logic [1:0]      bg,
  input  logic            par,
  output logic            ACT,
  output logic            PR,
  output logic            PRA,
  output logic            RD,
  output logic            RDA,
  output logic            WR,
  output logic            WRA,
  output logic            REF,
  output logic            MRW,
  output logic            CFG,
  output logic            SRF,
  output logic            PD,
  output logic            PDX,
  output logic            CKEH,
  output logic            CKEL,
  output logic            BST,
  output logic            MRR,
  output logic            DPD,
  output logic            DPDX,
  output logic            halt,
  output logic            ill_cmd,
  output logic            par_err,
  output logic [7:0]      err_cnt,
  output logic [1:0]      cmd_bg,
  output logic [1:0]      cmd_ba,
  output logic [ADRW-1:0] cmd_row,
  output logic [COLW-1:0] cmd_col
);

  pstate_t         state_q, state_d;
  logic            cke_q, cke_d;
  strobes_t        strb_q, strb_d;
  logic [1:0]      cmd_bg_q, cmd_bg_d, cmd_ba_q, cmd_ba_d;
  logic [ADRW-1:0] cmd_row_q, cmd_row_d;
  logic [COLW-1:0] cmd_col_q, cmd_col_d;

  logic [2:0] op;
  logic       sel, nop, is_ref, perr, chk_en, cmd_ok, accept, cke_fall, cke_rise;

  assign op       = adr[ADRW-1 -: 3];
  assign sel      = ~cs_n;
  assign nop      = act_n & (op == OP_NOP);
  assign is_ref   = act_n & (op == OP_REF);
  assign cke_fall = cke_q & ~cke;
  assign cke_rise = ~cke_q & cke;
  assign chk_en   = sel & reset_n & (state_q == ACTIVE);
  assign cmd_ok   = chk_en & cke & cke_q & ~perr;
  assign accept   = cmd_ok & ~nop & ~(act_n & (op == OP_RFU));

  ddr4_ca_parity #(
    .ADRW      (ADRW),
    .PARITY_EN (PARITY_EN)
  ) u_parity (
    .clk      (clk),
    .rst      (rst),
    .chk_en   (chk_en),
    .act_n    (act_n),
    .adr      (adr),
    .bg       (bg),
    .ba       (ba),
    .par      (par),
    .mismatch (perr),
    .err_cnt  (err_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PWRUP;
      cke_q     <= 1'b0;
      strb_q    <= '0;
      cmd_bg_q  <= '0;
      cmd_ba_q  <= '0;
      cmd_row_q <= '0;
      cmd_col_q <= '0;
    end else begin
      state_q   <= state_d;
      cke_q     <= cke_d;
      strb_q    <= strb_d;
      cmd_bg_q  <= cmd_bg_d;
      cmd_ba_q  <= cmd_ba_d;
      cmd_row_q <= cmd_row_d;
      cmd_col_q <= cmd_col_d;
    end
  end

  // A parity-failed edge never changes power state, even on a CKE fall.
  always_comb begin
    cke_d   = cke;
    state_d = state_q;
    case (state_q)
      PWRUP:   if (cke) state_d = ACTIVE;
      ACTIVE:  if (cke_fall && !perr) state_d = (sel && is_ref) ? SREF : PDN;
      PDN:     if (cke_rise) state_d = ACTIVE;
      SREF:    if (cke_rise) state_d = ACTIVE;
      default: state_d = PWRUP;
    endcase
    if (!reset_n) state_d = PWRUP;
  end

  always_comb begin
    strb_d      = '0;
    cmd_bg_d    = cmd_bg_q;
    cmd_ba_d    = cmd_ba_q;
    cmd_row_d   = cmd_row_q;
    cmd_col_d   = cmd_col_q;
    strb_d.perr = perr;
    if (reset_n) begin
      case (state_q)
        ACTIVE: begin
          if (cke_fall && !perr) begin
            strb_d.ckel = 1'b1;
            if (sel && is_ref) begin
              strb_d.srf = 1'b1;
            end else begin
              strb_d.pd  = 1'b1;
              strb_d.ill = sel & ~nop;
            end
          end else if (cmd_ok) begin
            if (!act_n) begin
              strb_d.act = 1'b1;
              cmd_row_d  = adr;
            end else begin
              case (op)
                OP_MRS: strb_d.mrw  = 1'b1;
                OP_REF: strb_d.refr = 1'b1;
                OP_PRE: begin
                  strb_d.pra = adr[A10];
                  strb_d.pr  = ~adr[A10];
                end
                OP_WR: begin
                  strb_d.wra = adr[A10];
                  strb_d.wr  = ~adr[A10];
                  cmd_col_d  = adr[COLW-1:0];
                end
                OP_RD: begin
                  strb_d.rda = adr[A10];
                  strb_d.rd  = ~adr[A10];
                  cmd_col_d  = adr[COLW-1:0];
                end
                OP_ZQC:  strb_d.cfg = 1'b1;
                OP_RFU:  strb_d.ill = 1'b1;
                default: ;
              endcase
            end
            if (accept) begin
              cmd_bg_d = bg;
              cmd_ba_d = ba;
            end
          end else if (sel && !cke && !cke_q && !nop && !perr) begin
            strb_d.ill = 1'b1;
          end
        end
        PDN: begin
          strb_d.pdx  = cke_rise;
          strb_d.ckeh = cke_rise;
        end
        SREF:    strb_d.ckeh = cke_rise;
        default: ;
      endcase
    end
  end

  assign ACT     = strb_q.act;
  assign PR      = strb_q.pr;
  assign PRA     = strb_q.pra;
  assign RD      = strb_q.rd;
  assign RDA     = strb_q.rda;
  assign WR      = strb_q.wr;
  assign WRA     = strb_q.wra;
  assign REF     = strb_q.refr;
  assign MRW     = strb_q.mrw;
  assign CFG     = strb_q.cfg;
  assign SRF     = strb_q.srf;
  assign PD      = strb_q.pd;
  assign PDX     = strb_q.pdx;
  assign CKEH    = strb_q.ckeh;
  assign CKEL    = strb_q.ckel;
  assign BST     = 1'b0;
  assign MRR     = 1'b0;
  assign DPD     = 1'b0;
  assign DPDX    = 1'b0;
  assign ill_cmd = strb_q.ill;
  assign par_err = strb_q.perr;
  assign halt    = (state_q == PWRUP);
  assign cmd_bg  = cmd_bg_q;
  assign cmd_ba  = cmd_ba_q;
  assign cmd_row = cmd_row_q;
  assign cmd_col = cmd_col_q;

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// Self-checking bench for ddr4_cmd_decoder: directed scenarios plus random CA traffic,
// compared every cycle against a command-name level model of the DIMM pin protocol.
module tb_ddr4_cmd_decoder;

  localparam int ADRW      = 17;
  localparam int COLW      = 10;
  localparam bit PARITY_EN = 1'b1;

  localparam int ST_PWRUP  = 0;
  localparam int ST_ACTIVE = 1;
  localparam int ST_PDN    = 2;
  localparam int ST_SREF   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1, reset_n = 1'b1, cke = 1'b0, cs_n = 1'b1, act_n = 1'b1, par = 1'b0;
  logic [ADRW-1:0] adr = '1;
  logic [1:0] ba = '0, bg = '0;

  logic act_o, pr_o, pra_o, rd_o, rda_o, wr_o, wra_o, ref_o, mrw_o, cfg_o;
  logic srf_o, pd_o, pdx_o, ckeh_o, ckel_o, bst_o, mrr_o, dpd_o, dpdx_o;
  logic halt, ill_cmd, par_err;
  logic [7:0] err_cnt;
  logic [1:0] cmd_bg, cmd_ba;
  logic [ADRW-1:0] cmd_row;
  logic [COLW-1:0] cmd_col;

  int vectors = 0;
  int miscompares = 0;

  string names [21] = '{"ACT", "PR", "PRA", "RD", "RDA", "WR", "WRA", "REF", "MRW", "CFG",
                        "SRF", "PD", "PDX", "CKEH", "CKEL", "BST", "MRR", "DPD", "DPDX",
                        "ILL", "PERR"};

  // model state and the outputs it predicts for the cycle after the next edge
  int  m_st = ST_PWRUP;
  bit  m_ckeq = 1'b0;
  int  m_cnt = 0;
  bit  model_valid = 1'b0;
  bit  exp_on [string];
  string e_str = "";
  bit  e_halt = 1'b1;
  logic [7:0] e_cnt = '0;
  logic [1:0] e_bg = '0, e_ba = '0;
  logic [ADRW-1:0] e_row = '0;
  logic [COLW-1:0] e_col = '0;

  ddr4_cmd_decoder #(.ADRW(ADRW), .COLW(COLW), .PARITY_EN(PARITY_EN)) dut (
    .clk(clk), .rst(rst), .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .adr(adr), .ba(ba), .bg(bg), .par(par),
    .ACT(act_o), .PR(pr_o), .PRA(pra_o), .RD(rd_o), .RDA(rda_o), .WR(wr_o), .WRA(wra_o),
    .REF(ref_o), .MRW(mrw_o), .CFG(cfg_o), .SRF(srf_o), .PD(pd_o), .PDX(pdx_o),
    .CKEH(ckeh_o), .CKEL(ckel_o), .BST(bst_o), .MRR(mrr_o), .DPD(dpd_o), .DPDX(dpdx_o),
    .halt(halt), .ill_cmd(ill_cmd), .par_err(par_err), .err_cnt(err_cnt),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col)
  );

  always #5 clk = ~clk;

  function automatic string cmdName(input logic actn, input logic [2:0] op, input logic a10);
    if (!actn) return "ACT";
    case (op)
      3'd0:    return "MRW";
      3'd1:    return "REF";
      3'd2:    return a10 ? "PRA" : "PR";
      3'd3:    return "ILL";
      3'd4:    return a10 ? "WRA" : "WR";
      3'd5:    return a10 ? "RDA" : "RD";
      3'd6:    return "CFG";
      default: return "NOP";
    endcase
  endfunction

  function automatic string dutStrobes();
    logic b [21];
    string s = "";
    b = '{act_o, pr_o, pra_o, rd_o, rda_o, wr_o, wra_o, ref_o, mrw_o, cfg_o, srf_o, pd_o,
          pdx_o, ckeh_o, ckel_o, bst_o, mrr_o, dpd_o, dpdx_o, ill_cmd, par_err};
    for (int i = 0; i < 21; i++) if (b[i] !== 1'b0) s = {s, names[i], " "};
    return s;
  endfunction

  // Predicts the effect of the pins now being driven on the coming clock edge.
  task automatic modelStep();
    bit sel, nop, is_ref, fall, rise, bad;
    int nxt;
    string nm, s;
    exp_on.delete();
    if (rst) begin
      m_st = ST_PWRUP; m_ckeq = 1'b0; m_cnt = 0;
      e_bg = '0; e_ba = '0; e_row = '0; e_col = '0;
    end else begin
      sel    = !cs_n;
      nm     = cmdName(act_n, adr[ADRW-1 -: 3], adr[10]);
      nop    = (nm == "NOP");
      is_ref = (nm == "REF");
      fall   = m_ckeq && !cke;
      rise   = !m_ckeq && cke;
      bad    = PARITY_EN && sel && reset_n && (m_st == ST_ACTIVE) && (^{act_n, adr, bg, ba, par});
      nxt    = m_st;
      if (bad) begin
        exp_on["PERR"] = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
      if (!reset_n) nxt = ST_PWRUP;
      else if (m_st == ST_PWRUP) begin
        if (cke) nxt = ST_ACTIVE;
      end else if (m_st == ST_ACTIVE) begin
        if (!bad && fall) begin
          exp_on["CKEL"] = 1'b1;
          if (sel && is_ref) begin
            exp_on["SRF"] = 1'b1; nxt = ST_SREF;
          end else begin
            exp_on["PD"] = 1'b1; nxt = ST_PDN;
            if (sel && !nop) exp_on["ILL"] = 1'b1;
          end
        end else if (!bad && sel && cke && m_ckeq && !nop) begin
          exp_on[nm] = 1'b1;
          if (nm != "ILL") begin
            e_bg = bg; e_ba = ba;
            if (nm == "ACT") e_row = adr;
            if (nm == "RD" || nm == "RDA" || nm == "WR" || nm == "WRA") e_col = adr[COLW-1:0];
          end
        end else if (!bad && sel && !cke && !m_ckeq && !nop) begin
          exp_on["ILL"] = 1'b1;
        end
      end else if (rise) begin
        exp_on["CKEH"] = 1'b1;
        if (m_st == ST_PDN) exp_on["PDX"] = 1'b1;
        nxt = ST_ACTIVE;
      end
      m_st   = nxt;
      m_ckeq = cke;
    end
    s = "";
    for (int i = 0; i < 21; i++) if (exp_on.exists(names[i])) s = {s, names[i], " "};
    e_str  = s;
    e_halt = (m_st == ST_PWRUP);
    e_cnt  = 8'(m_cnt);
    model_valid = 1'b1;
  endtask

  task automatic applyStimulus(input bit r, input bit rn, input bit ck, input bit csn,
                               input bit actn, input logic [ADRW-1:0] a, input logic [1:0] g,
                               input logic [1:0] b, input bit good_par);
    @(negedge clk);
    #1;
    rst = r; reset_n = rn; cke = ck; cs_n = csn; act_n = actn; adr = a; bg = g; ba = b;
    par = (^{actn, a, g, b}) ^ ~good_par;
    modelStep();
  endtask

  task automatic idle(input bit ck);
    applyStimulus(1'b0, 1'b1, ck, 1'b1, 1'b1, '1, 2'd0, 2'd0, 1'b1);
  endtask

  task automatic issue(input bit ck, input logic [2:0] op, input logic [13:0] low,
                       input logic [1:0] g, input logic [1:0] b);
    applyStimulus(1'b0, 1'b1, ck, 1'b0, 1'b1, {op, low}, g, b, 1'b1);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic cmpVal(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, got, req);
    end
  endtask

  task automatic checkOutput();
    string got;
    got = dutStrobes();
    vectors++;
    if (got != e_str) begin
      miscompares++;
      $display("[TB] FAIL strobes at %0t: got \"%s\", required \"%s\"", $time, got, e_str);
    end
    cmpVal("halt", 32'(halt), 32'(e_halt));
    cmpVal("err_cnt", 32'(err_cnt), 32'(e_cnt));
    cmpVal("cmd_bg", 32'(cmd_bg), 32'(e_bg));
    cmpVal("cmd_ba", 32'(cmd_ba), 32'(e_ba));
    cmpVal("cmd_row", 32'(cmd_row), 32'(e_row));
    cmpVal("cmd_col", 32'(cmd_col), 32'(e_col));
  endtask

  always @(negedge clk) if (model_valid) checkOutput();

  initial begin
    logic [13:0] low;
    bit ck;
    logic [2:0] sweep [6] = '{3'd5, 3'd4, 3'd2, 3'd1, 3'd0, 3'd6};

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, '1, 2'd0, 2'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, '1, 2'd0, 2'd0, 1'b1);
    settle();
    cmpVal("pin_reset_halt", 32'(halt), 32'd1);
    cmpVal("pin_reset_errcnt", 32'(err_cnt), 32'd0);

    idle(1'b1);
    settle();
    cmpVal("pin_halt_falls", 32'(halt), 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h1ABCD, 2'd2, 2'd1, 1'b1);
    settle();
    cmpVal("pin_act", 32'(act_o), 32'd1);
    cmpVal("pin_act_row", 32'(cmd_row), 32'h1ABCD);
    cmpVal("pin_act_bg", 32'(cmd_bg), 32'd2);
    cmpVal("pin_act_ba", 32'(cmd_ba), 32'd1);
    idle(1'b1);
    settle();
    cmpVal("pin_act_one_cycle", 32'(act_o), 32'd0);

    issue(1'b1, 3'd5, 14'h0155, 2'd1, 2'd3);
    settle();
    cmpVal("pin_rd", 32'(rd_o), 32'd1);
    cmpVal("pin_rd_col", 32'(cmd_col), 32'h155);
    issue(1'b1, 3'd5, 14'h0555, 2'd0, 2'd2);
    settle();
    cmpVal("pin_rda", 32'(rda_o), 32'd1);

    for (int a10 = 0; a10 < 2; a10++) begin
      for (int k = 0; k < 6; k++) begin
        low = 14'($urandom);
        low[10] = a10[0];
        issue(1'b1, sweep[k], low, 2'($urandom), 2'($urandom));
        idle(1'b1);
      end
    end

    issue(1'b0, 3'd1, 14'h0000, 2'd0, 2'd0);
    settle();
    cmpVal("pin_srf", 32'(srf_o), 32'd1);
    cmpVal("pin_srf_ckel", 32'(ckel_o), 32'd1);
    cmpVal("pin_srf_no_ref", 32'(ref_o), 32'd0);
    for (int i = 0; i < 20; i++) issue(1'b0, 3'd5, 14'($urandom), 2'd1, 2'd1);
    idle(1'b1);
    settle();
    cmpVal("pin_sref_ckeh", 32'(ckeh_o), 32'd1);
    cmpVal("pin_sref_no_pdx", 32'(pdx_o), 32'd0);

    issue(1'b0, 3'd7, 14'h3FFF, 2'd0, 2'd0);
    settle();
    cmpVal("pin_pd", 32'(pd_o), 32'd1);
    cmpVal("pin_pd_ckel", 32'(ckel_o), 32'd1);
    for (int i = 0; i < 3; i++) idle(1'b0);
    issue(1'b1, 3'd5, 14'h0020, 2'd0, 2'd0);
    settle();
    cmpVal("pin_pdx", 32'(pdx_o), 32'd1);
    cmpVal("pin_pdx_ckeh", 32'(ckeh_o), 32'd1);
    cmpVal("pin_exit_rd_ignored", 32'(rd_o), 32'd0);
    issue(1'b1, 3'd5, 14'h0021, 2'd0, 2'd0);
    settle();
    cmpVal("pin_rd_after_exit", 32'(rd_o), 32'd1);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h00F0F, 2'd1, 2'd1, 1'b0);
    settle();
    cmpVal("pin_bad_par_no_act", 32'(act_o), 32'd0);
    cmpVal("pin_par_err", 32'(par_err), 32'd1);
    cmpVal("pin_err_cnt_1", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 299; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'($urandom), 2'($urandom), 2'($urandom), 1'b0);
    settle();
    cmpVal("pin_err_cnt_sat", 32'(err_cnt), 32'd255);

    issue(1'b1, 3'd3, 14'h0000, 2'd0, 2'd0);
    settle();
    cmpVal("pin_rfu_ill", 32'(ill_cmd), 32'd1);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h00001, 2'd0, 2'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 17'h14000, 2'd0, 2'd0, 1'b1);
    settle();
    cmpVal("pin_resetn_halt", 32'(halt), 32'd1);
    cmpVal("pin_resetn_no_rd", 32'(rd_o), 32'd0);
    idle(1'b1);
    idle(1'b1);

    issue(1'b0, 3'd1, 14'h0000, 2'd0, 2'd0);
    idle(1'b0);
    idle(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, '1, 2'd0, 2'd0, 1'b1);
    settle();
    cmpVal("pin_rst_sref_halt", 32'(halt), 32'd1);
    cmpVal("pin_rst_sref_errcnt", 32'(err_cnt), 32'd0);

    ck = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ck = ~ck;
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 39) != 0, ck,
                    1'($urandom), 1'($urandom), 17'($urandom), 2'($urandom), 2'($urandom),
                    $urandom_range(0, 9) != 0);
    end
    idle(1'b1);
    @(negedge clk);
    #1;
    model_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
